// File: rtl/nonce_result_reader_if.sv
// Bus bundle between the nonce result reader and its environment:
// scan control, result memory port and scan results.
interface nonce_result_reader_if;
    logic        start;
    logic [15:0] output_addr;
    logic [31:0] target;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        done;
    logic [31:0] best_hash;
    logic [3:0]  best_nonce;
    logic        found;
    logic [4:0]  found_count;

    modport slave (
        input  start, input output_addr, input target, input mem_read_data,
        output mem_clk, output mem_we, output mem_addr,
        output busy, output done, output best_hash, output best_nonce,
        output found, output found_count
    );

    modport master (
        output start, output output_addr, output target, output mem_read_data,
        input  mem_clk, input mem_we, input mem_addr,
        input  busy, input done, input best_hash, input best_nonce,
        input  found, input found_count
    );
endinterface

// File: rtl/nonce_result_reader.sv
// Scans NUM_NONCES hash result words from memory, tracking the smallest word,
// its index, and how many words fall strictly below the difficulty target.
module nonce_result_reader #(
    parameter int NUM_NONCES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    nonce_result_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_NONCES - 1);

    state_t      state_q,       state_d;
    logic [3:0]  issue_cnt_q,   issue_cnt_d;
    logic [15:0] mem_addr_q,    mem_addr_d;
    logic [31:0] target_q,      target_d;
    logic        rd_pend_q,     rd_pend_d;
    logic [3:0]  rd_idx_q,      rd_idx_d;
    logic [31:0] run_min_q,     run_min_d;
    logic [3:0]  run_idx_q,     run_idx_d;
    logic [4:0]  run_cnt_q,     run_cnt_d;
    logic        busy_q,        busy_d;
    logic        done_q,        done_d;
    logic [31:0] best_hash_q,   best_hash_d;
    logic [3:0]  best_nonce_q,  best_nonce_d;
    logic        found_q,       found_d;
    logic [4:0]  found_count_q, found_count_d;

    logic [31:0] cap_min_s;
    logic [3:0]  cap_idx_s;
    logic [4:0]  cap_cnt_s;

    // Fold the word returned for last cycle's address into the running min/count.
    always_comb begin
        cap_min_s = run_min_q;
        cap_idx_s = run_idx_q;
        cap_cnt_s = run_cnt_q;
        if (rd_pend_q) begin
            // word 0 seeds the minimum; later words replace it only when strictly smaller
            if ((rd_idx_q == 4'd0) || (bus.mem_read_data < run_min_q)) begin
                cap_min_s = bus.mem_read_data;
                cap_idx_s = rd_idx_q;
            end else begin
                cap_min_s = run_min_q;
                cap_idx_s = run_idx_q;
            end
            if (bus.mem_read_data < target_q) begin
                cap_cnt_s = run_cnt_q + 5'd1;
            end else begin
                cap_cnt_s = run_cnt_q;
            end
        end else begin
            cap_min_s = run_min_q;
            cap_idx_s = run_idx_q;
            cap_cnt_s = run_cnt_q;
        end
    end

    // Scan sequencing: next state, address generation and result publication.
    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        mem_addr_d    = mem_addr_q;
        target_d      = target_q;
        rd_pend_d     = (state_q == ISSUE);
        rd_idx_d      = issue_cnt_q;
        run_min_d     = cap_min_s;
        run_idx_d     = cap_idx_s;
        run_cnt_d     = cap_cnt_s;
        best_hash_d   = best_hash_q;
        best_nonce_d  = best_nonce_q;
        found_d       = found_q;
        found_count_d = found_count_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d    = bus.target;
                    mem_addr_d  = bus.output_addr;
                    issue_cnt_d = 4'd0;
                    run_min_d   = 32'hFFFF_FFFF;
                    run_idx_d   = 4'd0;
                    run_cnt_d   = 5'd0;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // address stays on the last word while the final read drains
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                    mem_addr_d  = mem_addr_q + 16'd1;
                end
            end
            DRAIN: begin
                // the last word arrives this cycle, so publish the folded values directly
                best_hash_d   = cap_min_s;
                best_nonce_d  = cap_idx_s;
                found_d       = (cap_min_s < target_q);
                found_count_d = cap_cnt_s;
                state_d       = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == FINISH);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            issue_cnt_q   <= 4'd0;
            mem_addr_q    <= 16'd0;
            target_q      <= 32'd0;
            rd_pend_q     <= 1'b0;
            rd_idx_q      <= 4'd0;
            run_min_q     <= 32'hFFFF_FFFF;
            run_idx_q     <= 4'd0;
            run_cnt_q     <= 5'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_hash_q   <= 32'hFFFF_FFFF;
            best_nonce_q  <= 4'd0;
            found_q       <= 1'b0;
            found_count_q <= 5'd0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            mem_addr_q    <= mem_addr_d;
            target_q      <= target_d;
            rd_pend_q     <= rd_pend_d;
            rd_idx_q      <= rd_idx_d;
            run_min_q     <= run_min_d;
            run_idx_q     <= run_idx_d;
            run_cnt_q     <= run_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_hash_q   <= best_hash_d;
            best_nonce_q  <= best_nonce_d;
            found_q       <= found_d;
            found_count_q <= found_count_d;
        end
    end

    assign bus.mem_clk     = clk;
    assign bus.mem_we      = 1'b0;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.best_hash   = best_hash_q;
    assign bus.best_nonce  = best_nonce_q;
    assign bus.found       = found_q;
    assign bus.found_count = found_count_q;

endmodule

// File: tb/tb_nonce_result_reader.sv
// Randomised and directed scenarios for nonce_result_reader against a
// behavioural model of the minimum search and threshold count.
module tb_nonce_result_reader;
    localparam int N = 16;

    logic clk;
    logic reset;
    nonce_result_reader_if bus();

    nonce_result_reader #(.NUM_NONCES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] words [N];
    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: address in cycle t gives data in cycle t+1.
    always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

    task automatic load_words(input logic [15:0] base);
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            a = base + 16'(i);
            mem[a] = words[i];
        end
    endtask

    task automatic ref_model(input logic [31:0] tgt, output logic [31:0] mn,
                             output logic [3:0] idx, output logic [4:0] cnt, output logic fnd);
        mn = words[0]; idx = 4'd0; cnt = 5'd0;
        for (int i = 0; i < N; i++) begin
            if (words[i] < mn) begin mn = words[i]; idx = 4'(i); end
            if (words[i] < tgt) cnt = cnt + 5'd1;
        end
        fnd = (mn < tgt);
    endtask

    // Drives one start and observes N+6 cycles; collects timing/sequence observations.
    task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt,
                            output int done_cyc, output int pulses, output int addr_err,
                            output int busy_err, output int hold_err, output int we_err);
        logic [31:0] h0;
        logic [3:0]  n0;
        logic        f0;
        logic [4:0]  c0;
        logic [15:0] ea;
        h0 = bus.best_hash; n0 = bus.best_nonce; f0 = bus.found; c0 = bus.found_count;
        done_cyc = -1; pulses = 0; addr_err = 0; busy_err = 0; hold_err = 0; we_err = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.output_addr = base; bus.target = tgt;
        for (int c = 1; c <= N + 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0; bus.output_addr = 16'($urandom); bus.target = $urandom;
            end
            if (bus.done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.busy !== ((c >= 1) && (c <= N + 1))) busy_err++;
            ea = base + 16'(c - 1);
            if ((c <= N) && (bus.mem_addr !== ea)) addr_err++;
            if (bus.mem_we !== 1'b0) we_err++;
            if ((c <= N + 1) && ((bus.best_hash !== h0) || (bus.best_nonce !== n0) ||
                                 (bus.found !== f0) || (bus.found_count !== c0))) hold_err++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_we, bus.mem_addr, bus.best_hash, bus.best_nonce, bus.found, bus.found_count}
            !== {1'b0, 1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFF, 4'd0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%b done=%b we=%b addr=%h hash=%h nonce=%0d found=%b cnt=%0d, expected 0 0 0 0000 ffffffff 0 0 0",
                     bus.busy, bus.done, bus.mem_we, bus.mem_addr, bus.best_hash, bus.best_nonce, bus.found, bus.found_count);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ascending();
        int dc, pu, ae, be, he, we;
        for (int i = 0; i < N; i++) words[i] = 32'h100 + 32'(i);
        load_words(16'h0010);
        run_scan(16'h0010, 32'h105, dc, pu, ae, be, he, we);
        n_checks++; if (dc !== N + 2) begin n_fail++; $display("FAIL asc_done_cycle: got %0d expected %0d", dc, N + 2); end
        n_checks++; if (pu !== 1) begin n_fail++; $display("FAIL asc_done_pulses: got %0d expected 1", pu); end
        n_checks++; if (ae !== 0) begin n_fail++; $display("FAIL asc_addr_seq: got %0d bad cycles expected 0", ae); end
        n_checks++; if (be !== 0) begin n_fail++; $display("FAIL asc_busy: got %0d bad cycles expected 0", be); end
        n_checks++; if (he !== 0) begin n_fail++; $display("FAIL asc_result_hold: got %0d changes expected 0", he); end
        n_checks++; if (bus.best_hash !== 32'h100) begin n_fail++; $display("FAIL asc_hash: got %h expected 00000100", bus.best_hash); end
        n_checks++; if (bus.best_nonce !== 4'd0) begin n_fail++; $display("FAIL asc_nonce: got %0d expected 0", bus.best_nonce); end
        n_checks++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL asc_found: got %b expected 1", bus.found); end
        n_checks++; if (bus.found_count !== 5'd5) begin n_fail++; $display("FAIL asc_count: got %0d expected 5", bus.found_count); end
    endtask

    task automatic test_single_min();
        int dc, pu, ae, be, he, we;
        for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
        words[9] = 32'h1;
        load_words(16'h2000);
        run_scan(16'h2000, 32'h0, dc, pu, ae, be, he, we);
        n_checks++; if (dc !== N + 2) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected %0d", dc, N + 2); end
        n_checks++; if (bus.best_hash !== 32'h1) begin n_fail++; $display("FAIL single_hash: got %h expected 00000001", bus.best_hash); end
        n_checks++; if (bus.best_nonce !== 4'd9) begin n_fail++; $display("FAIL single_nonce: got %0d expected 9", bus.best_nonce); end
        n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL single_found: got %b expected 0", bus.found); end
        n_checks++; if (bus.found_count !== 5'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", bus.found_count); end
    endtask

    task automatic test_ties();
        int dc, pu, ae, be, he, we;
        for (int i = 0; i < N; i++) words[i] = 32'h1000 + 32'(i * 3);
        words[3] = 32'h50; words[7] = 32'h50; words[12] = 32'h50;
        load_words(16'h3000);
        run_scan(16'h3000, 32'h50, dc, pu, ae, be, he, we);
        n_checks++; if (bus.best_nonce !== 4'd3) begin n_fail++; $display("FAIL tie_nonce: got %0d expected 3", bus.best_nonce); end
        n_checks++; if (bus.best_hash !== 32'h50) begin n_fail++; $display("FAIL tie_hash: got %h expected 00000050", bus.best_hash); end
        n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL tie_found: got %b expected 0", bus.found); end
        n_checks++; if (bus.found_count !== 5'd0) begin n_fail++; $display("FAIL tie_count: got %0d expected 0", bus.found_count); end
    endtask

    task automatic test_wrap();
        int dc, pu, ae, be, he, we;
        logic [31:0] mn; logic [3:0] ix; logic [4:0] ct; logic fd;
        for (int i = 0; i < N; i++) words[i] = $urandom;
        load_words(16'hFFF8);
        ref_model(32'h8000_0000, mn, ix, ct, fd);
        run_scan(16'hFFF8, 32'h8000_0000, dc, pu, ae, be, he, we);
        n_checks++; if (ae !== 0) begin n_fail++; $display("FAIL wrap_addr_seq: got %0d bad cycles expected 0", ae); end
        n_checks++; if (we !== 0) begin n_fail++; $display("FAIL wrap_mem_we: got %0d cycles with we=1 expected 0", we); end
        n_checks++; if ({bus.best_hash, bus.best_nonce, bus.found, bus.found_count} !== {mn, ix, fd, ct}) begin
            n_fail++;
            $display("FAIL wrap_result: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d",
                     bus.best_hash, bus.best_nonce, bus.found, bus.found_count, mn, ix, fd, ct);
        end
    endtask

    task automatic test_reset_mid();
        int dc, pu, ae, be, he, we, late_done;
        logic [31:0] mn; logic [3:0] ix; logic [4:0] ct; logic fd;
        for (int i = 0; i < N; i++) words[i] = $urandom_range(0, 1000);
        load_words(16'h4444);
        @(negedge clk);
        bus.start = 1'b1; bus.output_addr = 16'h4444; bus.target = 32'd500;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_addr, bus.best_hash, bus.best_nonce, bus.found, bus.found_count}
            !== {1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFF, 4'd0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL midreset_values: got busy=%b done=%b addr=%h hash=%h nonce=%0d found=%b cnt=%0d, expected reset values",
                     bus.busy, bus.done, bus.mem_addr, bus.best_hash, bus.best_nonce, bus.found, bus.found_count);
        end
        @(negedge clk);
        reset = 1'b0;
        late_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) late_done++;
        end
        n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", late_done); end
        ref_model(32'd500, mn, ix, ct, fd);
        run_scan(16'h4444, 32'd500, dc, pu, ae, be, he, we);
        n_checks++; if (dc !== N + 2) begin n_fail++; $display("FAIL midreset_done_cycle: got %0d expected %0d", dc, N + 2); end
        n_checks++; if ({bus.best_hash, bus.best_nonce, bus.found, bus.found_count} !== {mn, ix, fd, ct}) begin
            n_fail++;
            $display("FAIL midreset_result: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d",
                     bus.best_hash, bus.best_nonce, bus.found, bus.found_count, mn, ix, fd, ct);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        logic [31:0] mn; logic [3:0] ix; logic [4:0] ct; logic fd;
        logic [31:0] h37; logic [3:0] n37; logic [4:0] c37; logic f37;
        for (int i = 0; i < N; i++) words[i] = $urandom_range(0, 255);
        load_words(16'h0100);
        ref_model(32'd100, mn, ix, ct, fd);
        h37 = 32'h0; n37 = 4'd0; c37 = 5'd0; f37 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.output_addr = 16'h0100; bus.target = 32'd100;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dq.push_back(c);
            if (c == 37) begin h37 = bus.best_hash; n37 = bus.best_nonce; c37 = bus.found_count; f37 = bus.found; end
        end
        bus.start = 1'b0;
        n_checks++;
        if (dq.size() != 2 || dq[0] != 18 || dq[1] != 37) begin
            n_fail++;
            $display("FAIL b2b_done_cycles: got %0d pulses (first %0d) expected 2 at 18 and 37",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1);
        end
        n_checks++; if ({h37, n37, f37, c37} !== {mn, ix, fd, ct}) begin
            n_fail++;
            $display("FAIL b2b_result: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d", h37, n37, f37, c37, mn, ix, fd, ct);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_random();
        int dc, pu, ae, be, he, we;
        logic [15:0] base;
        logic [31:0] tgt;
        logic [31:0] mn; logic [3:0] ix; logic [4:0] ct; logic fd;
        for (int it = 0; it < 8; it++) begin
            base = 16'($urandom);
            for (int i = 0; i < N; i++)
                words[i] = (it % 2 == 0) ? 32'($urandom_range(3, 12)) : $urandom;
            tgt = (it % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            load_words(base);
            ref_model(tgt, mn, ix, ct, fd);
            run_scan(base, tgt, dc, pu, ae, be, he, we);
            n_checks++;
            if ({dc, pu, ae, be, he, we} !== {N + 2, 1, 0, 0, 0, 0}) begin
                n_fail++;
                $display("FAIL rand%0d_timing: got done=%0d pulses=%0d addr_err=%0d busy_err=%0d hold_err=%0d we_err=%0d expected %0d 1 0 0 0 0",
                         it, dc, pu, ae, be, he, we, N + 2);
            end
            n_checks++;
            if ({bus.best_hash, bus.best_nonce, bus.found, bus.found_count} !== {mn, ix, fd, ct}) begin
                n_fail++;
                $display("FAIL rand%0d_result: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d",
                         it, bus.best_hash, bus.best_nonce, bus.found, bus.found_count, mn, ix, fd, ct);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFF_FFFF;
        bus.start = 1'b0;
        bus.output_addr = 16'h0000;
        bus.target = 32'h0;
        test_reset();
        test_ascending();
        test_single_min();
        test_ties();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
